dmem_ctrl: RTL



---
 rtl/dmem_pkg.sv | 57 +++++
 rtl/dmem_ctrl_sram.sv | 32 +++
 rtl/dmem_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Load/store encodings, pipeline record types and byte-lane helpers shared by
// the data-memory controller and its bench-facing top.
package dmem_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef struct packed {
        logic       we;
        logic       err;
        logic [2:0] op;
        logic [1:0] lane;
    } pipe_ctl_t;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } rsp_ent_t;

    function automatic logic [3:0] gen_be(input logic [2:0] op, input logic [1:0] lane);
        case (op)
            SB:      gen_be = 4'b0001 << lane;
            SH:      gen_be = 4'b0011 << lane;
            default: gen_be = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_rep(input logic [2:0] op, input logic [31:0] wd);
        case (op)
            SB:      lane_rep = {4{wd[7:0]}};
            SH:      lane_rep = {2{wd[15:0]}};
            default: lane_rep = wd;
        endcase
    endfunction

    // The addressed lane is shifted down to bit 0 before extension.
    function automatic logic [31:0] load_ext(input logic [2:0] op, input logic [1:0] lane,
                                             input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (op)
            LB:      load_ext = {{24{sh[7]}}, sh[7:0]};
            LBU:     load_ext = {24'h0, sh[7:0]};
            LH:      load_ext = {{16{sh[15]}}, sh[15:0]};
            LHU:     load_ext = {16'h0, sh[15:0]};
            default: load_ext = sh;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ctrl_sram.sv
// Behavioural single-port synchronous SRAM with per-byte write enables and a
// one-cycle registered read; replaced by the foundry macro wrapper in ASIC builds.
module sram_sp_bw #(
    parameter int AW = 13
) (
    input  logic          sclk,
    input  logic          cs,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    always_ff @(posedge sclk) begin
        if (cs) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata_q <= mem[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store data-memory controller: decodes and faults requests, drives the
// byte-write SRAM and returns in-order responses through a credit-guarded FIFO.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          AW        = 13,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          OUT_REG   = 0,
    parameter int          RSP_DEPTH = 4,
    parameter int          ECNT_W    = 16
) (
    input  logic              sclk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_op,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_we,
    output logic              rsp_err,
    output logic [31:0]       rsp_rdata,
    output logic [ECNT_W-1:0] err_cnt
);

    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    function automatic logic [ECNT_W-1:0] sat_inc(input logic [ECNT_W-1:0] v);
        return (&v) ? v : v + ECNT_W'(1);
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic              accept, pop;
    logic              out_of_range, illegal, misaligned, fault;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ECNT_W-1:0] ecnt_q, ecnt_d;
    logic              sram_cs;
    logic [3:0]        sram_be;
    logic [31:0]       sram_wdata, sram_rdata;
    logic              vld_p1_q, vld_p1_d;
    pipe_ctl_t         ctl_p1_q, ctl_p1_d;
    logic              push;
    pipe_ctl_t         push_ctl;
    logic [31:0]       push_raw;
    rsp_ent_t          push_ent, head;
    rsp_ent_t          fifo_q [RSP_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     fcnt_q, fcnt_d;

    // Credits cover every accepted request until its response is popped, so
    // the FIFO can never overflow and req_ready never sees rsp_ready.
    assign req_ready = (cnt_q < CW'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign rsp_valid = (fcnt_q != '0);
    assign pop       = rsp_valid & rsp_ready;

    // Stage 0: decode, fault check, SRAM access
    always_comb begin
        out_of_range = (req_addr[31:AW+2] != BASE_ADDR[31:AW+2]);
        illegal      = 1'b1;
        if (req_we) begin
            case (req_op)
                SB, SH, SW: illegal = 1'b0;
                default:    illegal = 1'b1;
            endcase
        end else begin
            case (req_op)
                LB, LH, LW, LBU, LHU: illegal = 1'b0;
                default:              illegal = 1'b1;
            endcase
        end
        misaligned = 1'b0;
        case (req_op[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            default: misaligned = 1'b0;
        endcase
        fault = out_of_range | illegal | misaligned;

        sram_cs    = accept & ~fault;
        sram_be    = gen_be(req_op, req_addr[1:0]);
        sram_wdata = lane_rep(req_op, req_wdata);

        vld_p1_d      = accept;
        ctl_p1_d.we   = req_we;
        ctl_p1_d.err  = fault;
        ctl_p1_d.op   = req_op;
        ctl_p1_d.lane = req_addr[1:0];

        cnt_d  = cnt_q + CW'(accept) - CW'(pop);
        ecnt_d = (accept & fault) ? sat_inc(ecnt_q) : ecnt_q;
    end

    sram_sp_bw #(.AW(AW)) u_sram (
        .sclk  (sclk),
        .cs    (sram_cs),
        .we    (req_we),
        .be    (sram_be),
        .addr  (req_addr[AW+1:2]),
        .wdata (sram_wdata),
        .rdata (sram_rdata)
    );

    // Stage 1: SRAM read data valid; optional stage 2 retimes it
    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic        vld_p2_q;
            pipe_ctl_t   ctl_p2_q;
            logic [31:0] rdata_p2_q;

            always_ff @(posedge sclk or negedge rstn) begin
                if (!rstn) vld_p2_q <= 1'b0;
                else       vld_p2_q <= vld_p1_q;
            end

            always_ff @(posedge sclk) begin
                ctl_p2_q   <= ctl_p1_q;
                rdata_p2_q <= sram_rdata;
            end

            assign push     = vld_p2_q;
            assign push_ctl = ctl_p2_q;
            assign push_raw = rdata_p2_q;
        end else begin : g_no_reg
            assign push     = vld_p1_q;
            assign push_ctl = ctl_p1_q;
            assign push_raw = sram_rdata;
        end
    endgenerate

    // Push stage: extend load data, FIFO pointer update
    always_comb begin
        push_ent.we    = push_ctl.we;
        push_ent.err   = push_ctl.err;
        push_ent.rdata = (push_ctl.we | push_ctl.err) ? '0
                       : load_ext(push_ctl.op, push_ctl.lane, push_raw);
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fcnt_d   = fcnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            cnt_q    <= '0;
            ecnt_q   <= '0;
            vld_p1_q <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fcnt_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            ecnt_q   <= ecnt_d;
            vld_p1_q <= vld_p1_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fcnt_q   <= fcnt_d;
        end
    end

    always_ff @(posedge sclk) begin
        ctl_p1_q <= ctl_p1_d;
        if (push) fifo_q[wr_ptr_q] <= push_ent;
    end

    // Entry storage is not reset, so the head is masked while the FIFO is empty.
    assign head      = fifo_q[rd_ptr_q];
    assign rsp_we    = rsp_valid & head.we;
    assign rsp_err   = rsp_valid & head.err;
    assign rsp_rdata = rsp_valid ? head.rdata : '0;
    assign err_cnt   = ecnt_q;

endmodule
